laser_feeder: RTL and testbench

LASER_FEEDER -- requirements
Module: laser_feeder

---
 rtl/laser_feeder.sv | 194 +++++++++++++++++++
 tb/tb_laser_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_feeder.sv
// laser_feeder: buffers 40 host points, streams them to a two-center solver,
// then scores how many stored points fall within radius 4 of either center.
module laser_feeder (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_EN,
    input  logic [3:0] WR_X,
    input  logic [3:0] WR_Y,
    input  logic       CLR,
    input  logic       START,
    output logic       SOL_RST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       FULL,
    output logic       BUSY,
    output logic       RES_VALID,
    output logic       ERR,
    output logic [3:0] RC1X,
    output logic [3:0] RC1Y,
    output logic [3:0] RC2X,
    output logic [3:0] RC2Y,
    output logic [5:0] COVER
);

    localparam logic [5:0]  NPTS  = 6'd40;
    localparam logic [5:0]  LAST  = 6'd39;
    localparam logic [15:0] WDMAX = 16'hFFFF;
    localparam logic [8:0]  R2    = 9'd16;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        SCORE,
        REPORT
    } state_t;

    state_t      state;
    logic [7:0]  pts [40];
    logic [5:0]  wcnt;
    logic [5:0]  idx;
    logic [5:0]  acc;
    logic [15:0] wdog;

    logic [7:0]  cur;
    logic [7:0]  nxt_pt;
    logic [5:0]  nxt;
    logic [5:0]  acc_nxt;
    logic        hit;
    logic        wr_ok;
    logic        start_ok;

    function automatic logic [3:0] absdiff(
        input logic [3:0] a,
        input logic [3:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // squared euclidean distance, 9 bits so 225+225 cannot overflow
    function automatic logic [8:0] dist2(
        input logic [3:0] px,
        input logic [3:0] py,
        input logic [3:0] cx,
        input logic [3:0] cy
    );
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = absdiff(px, cx);
        dy = absdiff(py, cy);
        sx = {4'd0, dx} * {4'd0, dx};
        sy = {4'd0, dy} * {4'd0, dy};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    assign cur      = pts[idx];
    assign nxt      = idx + 6'd1;
    assign nxt_pt   = pts[nxt];
    assign hit      = (dist2(cur[7:4], cur[3:0], RC1X, RC1Y) <= R2) ||
                      (dist2(cur[7:4], cur[3:0], RC2X, RC2Y) <= R2);
    assign acc_nxt  = acc + {5'd0, hit};
    assign FULL     = (wcnt == NPTS);
    assign wr_ok    = (state == IDLE) && !CLR && WR_EN && !FULL;
    assign start_ok = (state == IDLE) && !CLR && START && FULL;

    // point storage; contents survive reset and are only written from IDLE
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            pts[wcnt] <= {WR_X, WR_Y};
        end
    end

    // run sequencer: load, stream, wait for solver, score, report
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wcnt      <= 6'd0;
            idx       <= 6'd0;
            acc       <= 6'd0;
            wdog      <= 16'd0;
            SOL_RST   <= 1'b1;
            X         <= 4'd0;
            Y         <= 4'd0;
            BUSY      <= 1'b0;
            RES_VALID <= 1'b0;
            ERR       <= 1'b0;
            COVER     <= 6'd0;
            RC1X      <= 4'd0;
            RC1Y      <= 4'd0;
            RC2X      <= 4'd0;
            RC2Y      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLR) begin
                        wcnt <= 6'd0;
                    end else begin
                        if (wr_ok) begin
                            wcnt <= wcnt + 6'd1;
                        end
                        if (start_ok) begin
                            state   <= SEND;
                            idx     <= 6'd0;
                            X       <= pts[0][7:4];
                            Y       <= pts[0][3:0];
                            SOL_RST <= 1'b0;
                            BUSY    <= 1'b1;
                            ERR     <= 1'b0;
                            COVER   <= 6'd0;
                        end
                    end
                end
                SEND: begin
                    if (idx == LAST) begin
                        state <= WAIT;
                        X     <= 4'd0;
                        Y     <= 4'd0;
                        wdog  <= 16'd0;
                    end else begin
                        idx <= nxt;
                        X   <= nxt_pt[7:4];
                        Y   <= nxt_pt[3:0];
                    end
                end
                WAIT: begin
                    if (DONE) begin
                        state   <= SCORE;
                        RC1X    <= C1X;
                        RC1Y    <= C1Y;
                        RC2X    <= C2X;
                        RC2Y    <= C2Y;
                        SOL_RST <= 1'b1;
                        idx     <= 6'd0;
                        acc     <= 6'd0;
                    end else if (wdog == WDMAX) begin
                        state     <= REPORT;
                        SOL_RST   <= 1'b1;
                        ERR       <= 1'b1;
                        COVER     <= 6'd0;
                        RES_VALID <= 1'b1;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                SCORE: begin
                    if (idx == LAST) begin
                        state     <= REPORT;
                        COVER     <= acc_nxt;
                        RES_VALID <= 1'b1;
                    end else begin
                        idx <= nxt;
                        acc <= acc_nxt;
                    end
                end
                REPORT: begin
                    state     <= IDLE;
                    RES_VALID <= 1'b0;
                    BUSY      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_feeder.sv
// tb_laser_feeder: directed runs of laser_feeder checked every cycle
// against a run-timeline model plus hand-computed literal results.
module tb_laser_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_EN = 1'b0;
    logic [3:0] WR_X = 4'd0;
    logic [3:0] WR_Y = 4'd0;
    logic       CLR = 1'b0;
    logic       START = 1'b0;
    logic       DONE = 1'b0;
    logic [3:0] C1X = 4'd0;
    logic [3:0] C1Y = 4'd0;
    logic [3:0] C2X = 4'd0;
    logic [3:0] C2Y = 4'd0;
    logic       SOL_RST;
    logic [3:0] X;
    logic [3:0] Y;
    logic       FULL;
    logic       BUSY;
    logic       RES_VALID;
    logic       ERR;
    logic [3:0] RC1X;
    logic [3:0] RC1Y;
    logic [3:0] RC2X;
    logic [3:0] RC2Y;
    logic [5:0] COVER;

    int checks = 0;
    int errors = 0;

    laser_feeder dut (
        .CLK(CLK), .RST(RST),
        .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y),
        .CLR(CLR), .START(START),
        .SOL_RST(SOL_RST), .X(X), .Y(Y),
        .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .FULL(FULL), .BUSY(BUSY), .RES_VALID(RES_VALID), .ERR(ERR),
        .RC1X(RC1X), .RC1Y(RC1Y), .RC2X(RC2X), .RC2Y(RC2Y),
        .COVER(COVER)
    );

    always #5 CLK = ~CLK;

    // model: m_ph counts edges since the accepted START; m_W is the
    // number of WAIT cycles once known (0 = still waiting)
    logic [7:0]  m_pts [40];
    logic [15:0] m_rc = 16'd0;
    int m_wcnt = 0;
    int m_ph = 0;
    int m_W = 0;
    int m_cover = 0;
    bit m_run = 1'b0;
    bit m_to = 1'b0;
    bit m_err = 1'b0;

    function automatic bit near(input int px, input int py,
                                input int cx, input int cy);
        int dx;
        int dy;
        dx = px - cx;
        dy = py - cy;
        return (dx * dx + dy * dy) <= 16;
    endfunction

    function automatic int count_cov(input logic [15:0] c);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (near(int'(m_pts[i][7:4]), int'(m_pts[i][3:0]),
                     int'(c[15:12]), int'(c[11:8])) ||
                near(int'(m_pts[i][7:4]), int'(m_pts[i][3:0]),
                     int'(c[7:4]), int'(c[3:0])))
                n++;
        end
        return n;
    endfunction

    function automatic bit m_report();
        if (!m_run) return 1'b0;
        if (m_to) return m_ph == 41 + m_W;
        return (m_W > 0) && (m_ph == 81 + m_W);
    endfunction

    // model update on every edge, reset asynchronously like the host sees it
    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                m_wcnt = 0; m_run = 0; m_ph = 0; m_W = 0; m_to = 0;
                m_cover = 0; m_err = 0; m_rc = 16'd0;
            end else if (!m_run) begin
                if (CLR) begin
                    m_wcnt = 0;
                end else begin
                    if (START && m_wcnt == 40) begin
                        m_run = 1; m_ph = 1; m_W = 0; m_to = 0;
                        m_cover = 0; m_err = 0;
                    end
                    if (WR_EN && m_wcnt < 40) begin
                        m_pts[m_wcnt] = {WR_X, WR_Y};
                        m_wcnt++;
                    end
                end
            end else begin
                if (m_report()) begin
                    m_run = 0;
                    m_ph = 0;
                end else begin
                    if (m_W == 0 && m_ph > 40) begin
                        if (DONE) begin
                            m_W = m_ph - 40;
                            m_rc = {C1X, C1Y, C2X, C2Y};
                            m_cover = count_cov(m_rc);
                        end else if (m_ph - 40 == 65536) begin
                            m_W = 65536;
                            m_to = 1;
                            m_err = 1;
                            m_cover = 0;
                        end
                    end
                    m_ph++;
                end
            end
        end
    end

    logic [34:0] act_v;
    logic [34:0] exp_v;
    bit e_send;
    bit e_wait;
    bit e_rep;
    logic [7:0] e_pt;

    // per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge CLK);
            act_v = {SOL_RST, X, Y, BUSY, RES_VALID, ERR, FULL, COVER,
                     RC1X, RC1Y, RC2X, RC2Y};
            if (RST) begin
                exp_v = {1'b1, 34'd0};
            end else begin
                e_send = m_run && m_ph >= 1 && m_ph <= 40;
                e_wait = m_run && m_ph > 40 && (m_W == 0 || m_ph <= 40 + m_W);
                e_rep  = m_report();
                e_pt   = e_send ? m_pts[m_ph - 1] : 8'd0;
                exp_v = {!(e_send || e_wait), e_pt, m_run, e_rep,
                         (m_run && !e_rep) ? 1'b0 : m_err,
                         m_wcnt == 40,
                         (m_run && !e_rep) ? 6'd0 : 6'(m_cover),
                         m_rc};
            end
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle t=%0t actual=%h expected=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wr(input int x, input int y);
        WR_EN = 1'b1;
        WR_X = 4'(x);
        WR_Y = 4'(y);
        tick();
        WR_EN = 1'b0;
    endtask

    // lat = edges from the START cycle to the cycle showing RES_VALID
    task automatic run(input int d, input logic [15:0] c,
                       input bit junk, output int lat);
        lat = -1;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 1; n <= 70000 && lat < 0; n++) begin
            DONE = (d >= 0 && n == 41 + d) || (junk && n == 5);
            {C1X, C1Y, C2X, C2Y} = (junk && n == 5) ? 16'h0000 : c;
            {CLR, WR_EN, START} = (junk && n == 50) ? 3'b111 : 3'b000;
            if (RES_VALID) lat = n;
            else tick();
        end
        {DONE, CLR, WR_EN, START} = 4'b0000;
        tick();
    endtask

    int lat;
    int pulses;

    initial begin
        repeat (3) tick();
        chk("reset_sol_rst", SOL_RST, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_full", FULL, 0);
        chk("reset_cover", COVER, 0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 39; i++) wr(i % 16, i / 16);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("start39_busy", BUSY, 0);
        chk("start39_full", FULL, 0);
        wr(7, 2);
        chk("full40", FULL, 1);
        wr(15, 15);
        chk("full41", FULL, 1);

        // 19 points lie within r=4 of (3,3); none near (12,12)
        run(99, 16'h33CC, 1'b1, lat);
        chk("run1_latency", lat, 181);
        chk("run1_cover", COVER, 19);
        chk("run1_rc1x", RC1X, 3);
        chk("run1_rc2y", RC2Y, 12);
        chk("run1_err", ERR, 0);

        run(99, 16'h33CC, 1'b0, lat);
        chk("run2_latency", lat, 181);
        chk("run2_cover", COVER, 19);

        CLR = 1'b1;
        START = 1'b1;
        tick();
        {CLR, START} = 2'b00;
        chk("clr_start_busy", BUSY, 0);
        chk("clr_start_full", FULL, 0);

        for (int i = 0; i < 40; i++) wr(5, 5);
        run(3, 16'h15FF, 1'b0, lat);
        chk("edge_in_latency", lat, 85);
        chk("edge_in_cover", COVER, 40);
        run(3, 16'h00FF, 1'b0, lat);
        chk("edge_out_cover", COVER, 0);

        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 1; n < 60; n++) begin
            DONE = (n == 44);
            {C1X, C1Y, C2X, C2Y} = 16'h55AA;
            tick();
        end
        DONE = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_score_sol_rst", SOL_RST, 1);
        chk("rst_score_busy", BUSY, 0);
        tick();
        RST = 1'b0;
        pulses = 0;
        for (int n = 0; n < 100; n++) begin
            if (RES_VALID) pulses++;
            tick();
        end
        chk("rst_score_no_valid", pulses, 0);

        for (int i = 0; i < 40; i++) wr(i % 16, i / 16);
        run(-1, 16'h0000, 1'b0, lat);
        chk("timeout_latency", lat, 41 + 65536);
        chk("timeout_err", ERR, 1);
        chk("timeout_cover", COVER, 0);
        chk("timeout_rc1x", RC1X, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
